lfsr_param_gen: RTL and testbench

//  Parametrised N-bit LFSR pseudo-random generator, the successor of the fixed 5-bit internal-XOR LFSR.
//  - Feedback polynomial, width and seed are set by parameters.
//  - Selectable Galois (internal XOR) or Fibonacci (external XOR) structure.
//  - Adds step enable, runtime seed load and all-zero lockup protection.
//  - Adds built-in period measurement.
//  - Feeds BIST pattern generation and test-data scrambling in the 16-bit MIPS datapath.

---
 rtl/lfsr_param_gen.sv | 91 +++++++++
 tb/tb_lfsr_param_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/lfsr_param_gen.sv
// lfsr_param_gen: parametrised N-bit LFSR pattern generator.
// Galois (internal XOR) or Fibonacci (external XOR) structure, selected by MODE.
// Provides step enable, runtime seed load, zero-seed lockup protection and
// period measurement against a reference state (the last seed loaded).
// WIDTH must be at least 3. TAPS and SEED must be nonzero.
module lfsr_param_gen #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS = 16'hB400,
    parameter logic [WIDTH-1:0] SEED = 16'h0001,
    parameter int              MODE  = 0          // 0 = Galois, 1 = Fibonacci
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic             lockup,
    output logic             wrap,
    output logic [WIDTH-1:0] period_len
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_ref;         // state that counts as "one full period"
    logic [WIDTH-1:0] r_step_cnt;    // steps taken since r_ref was set or last wrap
    logic [WIDTH-1:0] r_period_len;
    logic             r_lockup;
    logic             r_wrap;

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_cnt_inc;
    logic             w_fb;
    logic             w_seed_zero;

    // Next LFSR state for the selected structure; both shift toward bit 0.
    always_comb begin
        // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
        w_next = '0;
        w_fb   = ^(r_state & TAPS);
        if (MODE == 0) begin
            w_next = (r_state >> 1) ^ (r_state[0] ? TAPS : '0);
        end else begin
            w_next = {w_fb, r_state[WIDTH-1:1]};
        end
    end

    assign w_cnt_inc   = r_step_cnt + 1'b1;
    assign w_seed_zero = (seed_in == '0);

    // Register update: load beats en; a zero seed is replaced by SEED, so the
    // register can never reach the all-zero lockup state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            r_state      <= SEED;
            r_ref        <= SEED;
            r_step_cnt   <= '0;
            r_period_len <= '0;
            r_lockup     <= 1'b0;
            r_wrap       <= 1'b0;
        end else if (load) begin
            r_state    <= w_seed_zero ? SEED : seed_in;
            r_ref      <= w_seed_zero ? SEED : seed_in;
            r_step_cnt <= '0;
            r_lockup   <= w_seed_zero;
            r_wrap     <= 1'b0;
        end else if (en) begin
            r_state  <= w_next;
            r_lockup <= 1'b0;
            if (w_next == r_ref) begin
                r_wrap       <= 1'b1;
                r_period_len <= w_cnt_inc;
                r_step_cnt   <= '0;
            end else begin
                r_wrap     <= 1'b0;
                r_step_cnt <= w_cnt_inc;
            end
        end else begin
            r_lockup <= 1'b0;
            r_wrap   <= 1'b0;
        end
    end

    assign state      = r_state;
    assign bit_out    = r_state[0];
    assign lockup     = r_lockup;
    assign wrap       = r_wrap;
    assign period_len = r_period_len;

endmodule

// File: tb/tb_lfsr_param_gen.sv
// Testbench for lfsr_param_gen at WIDTH=4: one Galois instance (TAPS=C) and
// one Fibonacci instance (TAPS=3), both with SEED=1.
module tb_lfsr_param_gen;

    logic       clk;
    logic       rst_n;
    logic       g_en, g_load;
    logic [3:0] g_seed;
    logic [3:0] g_state, g_period;
    logic       g_bit, g_lockup, g_wrap;
    logic       f_en, f_load;
    logic [3:0] f_seed;
    logic [3:0] f_state, f_period;
    logic       f_bit, f_lockup, f_wrap;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       en;
        logic       load;
        logic [3:0] seed;
        logic [3:0] st;
        logic       lk;
        logic       wr;
        logic [3:0] per;
    } vec_t;

    vec_t vecs [64];
    int   n_vec = 0;

    // Galois TAPS=C cycle starting at 1 (period 15), computed by hand.
    logic [3:0] gal_cyc [15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                                 4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};
    // Fibonacci TAPS=3 states after steps 1..5 from seed 1.
    logic [3:0] fib_exp [5] = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC};

    lfsr_param_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .MODE(0)) u_gal (
        .clk(clk), .rst_n(rst_n), .en(g_en), .load(g_load), .seed_in(g_seed),
        .state(g_state), .bit_out(g_bit), .lockup(g_lockup), .wrap(g_wrap),
        .period_len(g_period)
    );

    lfsr_param_gen #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h1), .MODE(1)) u_fib (
        .clk(clk), .rst_n(rst_n), .en(f_en), .load(f_load), .seed_in(f_seed),
        .state(f_state), .bit_out(f_bit), .lockup(f_lockup), .wrap(f_wrap),
        .period_len(f_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic e, input logic l, input logic [3:0] s,
                       input logic [3:0] st, input logic lk, input logic wr,
                       input logic [3:0] per);
        vecs[n_vec] = '{en: e, load: l, seed: s, st: st, lk: lk, wr: wr, per: per};
        n_vec++;
    endtask

    initial begin
        // Build the Galois vector table.
        for (int j = 1; j <= 15; j++)
            add(1'b1, 1'b0, 4'h0, gal_cyc[j % 15], 1'b0, (j == 15), (j == 15) ? 4'd15 : 4'd0);
        add(1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 4'd15);                  // hold
        for (int j = 1; j <= 3; j++)
            add(1'b1, 1'b0, 4'h0, gal_cyc[j], 1'b0, 1'b0, 4'd15);
        add(1'b0, 1'b1, 4'h0, 4'h1, 1'b1, 1'b0, 4'd15);                  // zero seed -> SEED, lockup
        for (int j = 1; j <= 15; j++)                                     // step_cnt restarted at 0
            add(1'b1, 1'b0, 4'h0, gal_cyc[j % 15], 1'b0, (j == 15), 4'd15);
        add(1'b1, 1'b1, 4'h7, 4'h7, 1'b0, 1'b0, 4'd15);                  // load beats en
        add(1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 4'd15);
        add(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 4'd15);                  // en=0 holds
        add(1'b1, 1'b0, 4'h0, 4'hB, 1'b0, 1'b0, 4'd15);
        for (int j = 3; j <= 15; j++)                                     // wrap back to new ref 7
            add(1'b1, 1'b0, 4'h0, gal_cyc[(8 + j) % 15], 1'b0, (j == 15), 4'd15);

        rst_n = 1'b0;
        g_en = 1'b0; g_load = 1'b0; g_seed = 4'h0;
        f_en = 1'b0; f_load = 1'b0; f_seed = 4'h0;
        @(negedge clk);
        @(negedge clk);

        check("rst_gal_state",  g_state,  4'h1);
        check("rst_gal_bit",    g_bit,    1'b1);
        check("rst_gal_lockup", g_lockup, 1'b0);
        check("rst_gal_wrap",   g_wrap,   1'b0);
        check("rst_gal_period", g_period, 4'h0);
        check("rst_fib_state",  f_state,  4'h1);
        rst_n = 1'b1;

        // Fibonacci sequence from reset, then one hold cycle.
        for (int k = 0; k < 5; k++) begin
            f_en = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("fib_step%0d", k + 1), f_state, fib_exp[k]);
            check($sformatf("fib_wrap%0d", k + 1), f_wrap, 1'b0);
        end
        f_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("fib_hold", f_state, 4'hC);
        check("gal_idle", g_state, 4'h1);

        // Galois table.
        for (int i = 0; i < n_vec; i++) begin
            g_en   = vecs[i].en;
            g_load = vecs[i].load;
            g_seed = vecs[i].seed;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_state", i),  g_state,  vecs[i].st);
            check($sformatf("v%0d_bit", i),    g_bit,    vecs[i].st[0]);
            check($sformatf("v%0d_lockup", i), g_lockup, vecs[i].lk);
            check($sformatf("v%0d_wrap", i),   g_wrap,   vecs[i].wr);
            check($sformatf("v%0d_period", i), g_period, vecs[i].per);
        end
        g_en = 1'b0; g_load = 1'b0; g_seed = 4'h0;

        // Wrap pulse lasts exactly one cycle.
        @(posedge clk);
        @(negedge clk);
        check("wrap_one_cycle", g_wrap, 1'b0);

        // Async reset mid-run after 5 steps from 7 (F,B,9,8,4), no wrap.
        g_en = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_rst_state", g_state, 4'h4);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state",  g_state,  4'h1);
        check("async_rst_period", g_period, 4'h0);
        check("async_rst_wrap",   g_wrap,   1'b0);
        check("async_rst_fib",    f_state,  4'h1);
        g_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_hold", g_state, 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
